// File: rtl/count_sequencer_pkg.sv
// Shared constants for the count sequencer family: FSM state encodings and
// direction codes.
package count_sequencer_pkg;

   localparam logic [1:0] ST_INIT     = 2'd0;
   localparam logic [1:0] ST_IDLE     = 2'd1;
   localparam logic [1:0] ST_COUNTING = 2'd2;
   localparam logic [1:0] ST_PAUSED   = 2'd3;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/count_next_calc.sv
// Combinational successor of the current count: one step up or down,
// clamped so the sequence lands exactly on the end value.
module count_next_calc
   import count_sequencer_pkg::*;
#(
   parameter int CW = 8
) (
   input  logic [CW-1:0] cur_i,
   input  logic [CW-1:0] end_i,
   input  logic [CW-1:0] step_i,
   input  logic          dir_i,
   output logic [CW-1:0] next_o,
   output logic          terminal_o
);

   logic [CW:0] sum_s;
   logic [CW:0] diff_s;

   // The extra top bit is the carry (up) or borrow (down), so overflow clamps to end
   always_comb begin
      sum_s  = {1'b0, cur_i} + {1'b0, step_i};
      diff_s = {1'b0, cur_i} - {1'b0, step_i};
      if (dir_i == DIR_UP) begin
         terminal_o = sum_s[CW] || (sum_s[CW-1:0] >= end_i);
      end else begin
         terminal_o = diff_s[CW] || (diff_s[CW-1:0] <= end_i);
      end
      if (terminal_o) begin
         next_o = end_i;
      end else if (dir_i == DIR_UP) begin
         next_o = sum_s[CW-1:0];
      end else begin
         next_o = diff_s[CW-1:0];
      end
   end

endmodule

// File: rtl/count_sequencer.sv
// Runtime-configurable up/down count sequencer with pause, abort, loop mode
// and a one-tick done pulse; everything advances only on clk_enable ticks.
module count_sequencer
   import count_sequencer_pkg::*;
#(
   parameter int COUNT_WIDTH = 8,
   parameter bit AUTO_DIR    = 1'b0,
   parameter bit AUTO_LOOP   = 1'b0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clk_enable,
   input  logic                   start,
   input  logic                   auto_start,
   input  logic                   pause,
   input  logic                   abort,
   input  logic [COUNT_WIDTH-1:0] cfg_start,
   input  logic [COUNT_WIDTH-1:0] cfg_end,
   input  logic [COUNT_WIDTH-1:0] cfg_step,
   input  logic                   cfg_dir,
   input  logic                   cfg_loop,
   output logic [COUNT_WIDTH-1:0] out,
   output logic                   out_valid,
   output logic                   out_last,
   output logic                   done,
   output logic                   busy
);

   localparam int CW = COUNT_WIDTH;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] s_q, s_d, e_q, e_d, stp_q, stp_d, out_q, out_d;
   logic          dir_q, dir_d, loop_q, loop_d;
   logic          valid_q, valid_d, last_q, last_d, done_q, done_d, busy_q, busy_d;

   logic [CW-1:0] calc_next_s;
   logic          calc_term_s;
   logic          begin_s;
   logic          run_dir_s;
   logic          run_loop_s;
   logic [CW-1:0] run_stp_s;

   // A start value already at or beyond the end (for the direction) is a one-value run
   function automatic logic first_is_last(input logic [CW-1:0] s, input logic [CW-1:0] e,
                                          input logic dir);
      if (dir == DIR_UP) begin
         return s >= e;
      end else begin
         return s <= e;
      end
   endfunction

   count_next_calc #(.CW(CW)) u_next_calc (
      .cur_i      (out_q),
      .end_i      (e_q),
      .step_i     (stp_q),
      .dir_i      (dir_q),
      .next_o     (calc_next_s),
      .terminal_o (calc_term_s)
   );

   // Run-start decode: explicit start, or auto_start on the very first tick out of reset
   always_comb begin
      begin_s = start || ((state_q == ST_INIT) && auto_start);
      if (start) begin
         run_dir_s  = cfg_dir;
         run_loop_s = cfg_loop;
      end else begin
         run_dir_s  = AUTO_DIR;
         run_loop_s = AUTO_LOOP;
      end
      if (cfg_step == '0) begin
         run_stp_s = {{(CW-1){1'b0}}, 1'b1};
      end else begin
         run_stp_s = cfg_step;
      end
   end

   // Next-state logic; priority is abort > start > pause > advance
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      e_d     = e_q;
      stp_d   = stp_q;
      dir_d   = dir_q;
      loop_d  = loop_q;
      out_d   = out_q;
      valid_d = valid_q;
      last_d  = last_q;
      done_d  = done_q;
      busy_d  = busy_q;
      if (clk_enable) begin
         if (abort) begin
            state_d = ST_IDLE;
            out_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b0;
            busy_d  = 1'b0;
         end else if (begin_s) begin
            state_d = ST_COUNTING;
            s_d     = cfg_start;
            e_d     = cfg_end;
            stp_d   = run_stp_s;
            dir_d   = run_dir_s;
            loop_d  = run_loop_s;
            out_d   = cfg_start;
            valid_d = 1'b1;
            last_d  = first_is_last(cfg_start, cfg_end, run_dir_s);
            done_d  = 1'b0;
            busy_d  = 1'b1;
         end else begin
            case (state_q)
               ST_COUNTING, ST_PAUSED: begin
                  done_d = 1'b0;
                  if (pause) begin
                     state_d = ST_PAUSED;
                  end else if (last_q && loop_q) begin
                     state_d = ST_COUNTING;
                     done_d  = 1'b1;
                     out_d   = s_q;
                     last_d  = first_is_last(s_q, e_q, dir_q);
                  end else if (last_q) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                     out_d   = '0;
                     valid_d = 1'b0;
                     last_d  = 1'b0;
                     busy_d  = 1'b0;
                  end else begin
                     state_d = ST_COUNTING;
                     out_d   = calc_next_s;
                     last_d  = calc_term_s;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
                  out_d   = '0;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  done_d  = 1'b0;
                  busy_d  = 1'b0;
               end
            endcase
         end
      end else begin
         state_d = state_q;
      end
   end

   // State, latched run configuration and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         s_q     <= '0;
         e_q     <= '0;
         stp_q   <= '0;
         dir_q   <= 1'b0;
         loop_q  <= 1'b0;
         out_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         e_q     <= e_d;
         stp_q   <= stp_d;
         dir_q   <= dir_d;
         loop_q  <= loop_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign out       = out_q;
   assign out_valid = valid_q;
   assign out_last  = last_q;
   assign done      = done_q;
   assign busy      = busy_q;

endmodule
